// File: rtl/fft4_sdf_ctrl.sv
// Sequencer for the 4-point radix-2 SDF FFT: delay config, sample intake, per-cycle butterfly/twiddle selects, output framing.
// Latency: first valid bin OUT_LAT cycles after sample 0 is accepted; selects are decoded from registered per-frame age counters.
// Backpressure: in_ready only in RUN (and not while stopping at a frame boundary); a mid-frame input gap cancels the frame and sets err.
module fft4_sdf_ctrl #(
    parameter int unsigned D1      = 2,
    parameter int unsigned D2      = 1,
    parameter int unsigned OUT_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       din_zero,
    output logic [3:0] dnum_s1,
    output logic [3:0] dnum_s2,
    output logic       bf1_sel,
    output logic       tw_sel,
    output logic       bf2_sel,
    output logic       out_valid,
    output logic       out_first,
    output logic       out_last,
    output logic [1:0] out_idx,
    output logic       busy,
    output logic       err
);

    // A frame schedule lives from s=1 to s=LAST; its age counter equals s.
    localparam int unsigned LAST = OUT_LAT + 3;
    localparam int unsigned AW   = $clog2(LAST + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CFG,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        k_q, k_d;
    logic              err_q, err_d;
    logic [3:0]        dnum_s1_q, dnum_s1_d;
    logic [3:0]        dnum_s2_q, dnum_s2_d;

    // Two schedule slots: a complete frame spans 7 cycles and frames start
    // at least 4 apart, so at most two schedules are ever live together.
    logic [1:0]        act_q, act_d;
    logic [1:0][AW-1:0] age_q, age_d;
    logic              cur_q, cur_d;

    logic              accept;
    logic              gap;
    logic              frame_start;
    logic [1:0]        retire;
    logic [1:0]        free;
    logic              alloc;
    logic [1:0]        m_off;

    assign in_ready    = (state_q == S_RUN) && !(stop && (k_q == 2'd0));
    assign accept      = in_valid && in_ready;
    assign din_zero    = !accept;
    assign gap         = (state_q == S_RUN) && (k_q != 2'd0) && !in_valid;
    assign frame_start = accept && (k_q == 2'd0);

    assign retire[0]   = act_q[0] && (age_q[0] == AW'(LAST));
    assign retire[1]   = act_q[1] && (age_q[1] == AW'(LAST));
    // A slot retiring this cycle can be reused by a frame starting this cycle.
    assign free        = ~act_q | retire;
    assign alloc       = !free[0];

    assign busy        = (state_q != S_IDLE);
    assign err         = err_q;
    assign dnum_s1     = dnum_s1_q;
    assign dnum_s2     = dnum_s2_q;

    // Control FSM next state: mode, sample counter, sticky error, delay config.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        err_d     = err_q;
        dnum_s1_d = dnum_s1_q;
        dnum_s2_d = dnum_s2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CFG;
                    err_d   = 1'b0;
                end
            end
            S_CFG: begin
                dnum_s1_d = 4'(D1);
                dnum_s2_d = 4'(D2);
                state_d   = S_RUN;
            end
            S_RUN: begin
                if (accept) begin
                    k_d = k_q + 2'd1;
                end else if (gap) begin
                    k_d   = 2'd0;
                    err_d = 1'b1;
                end
                // Leave at a frame boundary: either idle at k==0 or right
                // after the last sample of the frame in progress.
                if (stop && ((k_q == 2'd0) || (accept && (k_q == 2'd3)))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (&free) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Schedule slot next state: age live slots, cancel on gap, allocate on sample 0.
    always_comb begin
        act_d = act_q;
        age_d = age_q;
        cur_d = cur_q;
        for (int i = 0; i < 2; i++) begin
            if (retire[i[0]]) begin
                act_d[i[0]] = 1'b0;
            end else if (act_q[i[0]]) begin
                age_d[i[0]] = age_q[i[0]] + AW'(1);
            end
        end
        if (gap) begin
            act_d[cur_q] = 1'b0;
        end
        if (frame_start) begin
            act_d[alloc] = 1'b1;
            age_d[alloc] = AW'(1);
            cur_d        = alloc;
        end
    end

    // Output decode: OR of both slot schedules (disjoint per signal).
    always_comb begin
        bf1_sel   = 1'b0;
        bf2_sel   = 1'b0;
        tw_sel    = 1'b0;
        out_valid = 1'b0;
        out_first = 1'b0;
        out_last  = 1'b0;
        out_idx   = 2'd0;
        m_off     = 2'd0;
        for (int i = 0; i < 2; i++) begin
            if (act_q[i[0]]) begin
                bf1_sel = bf1_sel | (age_q[i[0]] == AW'(2)) | (age_q[i[0]] == AW'(3));
                bf2_sel = bf2_sel | (age_q[i[0]] == AW'(3)) | (age_q[i[0]] == AW'(5));
                tw_sel  = tw_sel  | (age_q[i[0]] == AW'(5));
                // Framing of a frame that is being cancelled this very cycle
                // (gap on its last sample) must not leak out.
                if ((age_q[i[0]] >= AW'(OUT_LAT)) && (age_q[i[0]] <= AW'(LAST)) &&
                    !(gap && (cur_q == i[0]))) begin
                    out_valid = 1'b1;
                    out_first = out_first | (age_q[i[0]] == AW'(OUT_LAT));
                    out_last  = out_last  | (age_q[i[0]] == AW'(LAST));
                    m_off     = 2'(age_q[i[0]] - AW'(OUT_LAT));
                    out_idx   = out_idx | {m_off[0], m_off[1]};
                end
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            k_q       <= 2'd0;
            err_q     <= 1'b0;
            dnum_s1_q <= 4'd0;
            dnum_s2_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            err_q     <= err_d;
            dnum_s1_q <= dnum_s1_d;
            dnum_s2_q <= dnum_s2_d;
        end
    end

    // Schedule slot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= 2'b00;
            age_q <= '0;
            cur_q <= 1'b0;
        end else begin
            act_q <= act_d;
            age_q <= age_d;
            cur_q <= cur_d;
        end
    end

endmodule

// File: tb/tb_fft4_sdf_ctrl.sv
// Self-checking bench for fft4_sdf_ctrl: directed stimulus with literal expectations
// plus a frame-list behavioural model compared against every output on every cycle.
// Inputs change 1ns after the rising edge; the model compares on the falling edge.
module tb_fft4_sdf_ctrl;

    localparam int OL = 3;
    localparam int MI = 0, MC = 1, MR = 2, MD = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready, din_zero;
    logic [3:0] dnum_s1, dnum_s2;
    logic       bf1_sel, tw_sel, bf2_sel;
    logic       out_valid, out_first, out_last;
    logic [1:0] out_idx;
    logic       busy, err;

    int n_cmp = 0;
    int n_bad = 0;

    fft4_sdf_ctrl #(.D1(2), .D2(1), .OUT_LAT(OL)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .in_valid(in_valid),
        .in_ready(in_ready), .din_zero(din_zero), .dnum_s1(dnum_s1), .dnum_s2(dnum_s2),
        .bf1_sel(bf1_sel), .tw_sel(tw_sel), .bf2_sel(bf2_sel),
        .out_valid(out_valid), .out_first(out_first), .out_last(out_last),
        .out_idx(out_idx), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] outs();
        return {in_ready, din_zero, dnum_s1, dnum_s2, bf1_sel, tw_sel, bf2_sel,
                out_valid, out_first, out_last, out_idx, busy, err};
    endfunction

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chkw(input string nm, input logic [19:0] got, input logic [19:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %05h expected %05h at %0t", nm, got, exp, $time);
        end
    endtask

    // Schedule outputs at offset s against per-signal bit vectors (bit s = value at s).
    task automatic chk_s(input string nm, input int s, input logic [11:0] b1, input logic [11:0] b2,
                         input logic [11:0] tw, input logic [11:0] ov, input logic [11:0] fi,
                         input logic [11:0] la);
        int tab[12];
        logic [1:0] ei;
        tab = '{0, 0, 0, 0, 2, 1, 3, 0, 2, 1, 3, 0};
        ei  = ov[s] ? 2'(tab[s]) : 2'd0;
        chkw($sformatf("%s s=%0d", nm, s),
             {12'd0, bf1_sel, bf2_sel, tw_sel, out_valid, out_first, out_last, out_idx},
             {12'd0, b1[s], b2[s], tw[s], ov[s], fi[s], la[s], ei});
    endtask

    task automatic tick(input logic v, input logic st, input logic sp);
        @(posedge clk);
        #1;
        in_valid = v;
        start    = st;
        stop     = sp;
        #1;
    endtask

    // ---------------- behavioural model ----------------
    int m_mode = MI;
    int m_k = 0;
    bit m_err = 1'b0;
    bit m_cfgd = 1'b0;
    int cyc = 0;
    int fst[$];   // cycle of sample 0 of each frame
    int fgp[$];   // cycle of the cancelling gap, -1 if complete

    always @(negedge clk) begin : model
        logic [19:0] gv, ev;
        bit e_rdy, e_acc, e_gap, b1, b2, tw, ov, fi, la, live, sel_ok, out_ok;
        logic [1:0] ix;
        int s, m, nmode;
        gv = outs();
        if (rst) begin
            m_mode = MI; m_k = 0; m_err = 1'b0; m_cfgd = 1'b0;
            fst.delete(); fgp.delete();
            ev = 20'h40000;
        end else begin
            e_rdy = (m_mode == MR) && !(stop && (m_k == 0));
            e_acc = in_valid && e_rdy;
            e_gap = (m_mode == MR) && (m_k != 0) && !in_valid;
            b1 = 0; b2 = 0; tw = 0; ov = 0; fi = 0; la = 0; ix = 2'd0;
            for (int i = 0; i < fst.size(); i++) begin
                s      = cyc - fst[i];
                sel_ok = (fgp[i] < 0) || (cyc <= fgp[i]);
                out_ok = (fgp[i] < 0) && !(e_gap && (i == fst.size() - 1));
                if (sel_ok) begin
                    b1 |= (s == 2) || (s == 3);
                    b2 |= (s == 3) || (s == 5);
                    tw |= (s == 5);
                end
                if (out_ok && s >= OL && s <= OL + 3) begin
                    ov = 1;
                    fi |= (s == OL);
                    la |= (s == OL + 3);
                    m  = s - OL;
                    ix = {m[0], m[1]};
                end
            end
            ev = {e_rdy, !e_acc, (m_cfgd ? 4'd2 : 4'd0), (m_cfgd ? 4'd1 : 4'd0),
                  b1, tw, b2, ov, fi, la, ix, (m_mode != MI), m_err};
            nmode = m_mode;
            case (m_mode)
                MI: if (start) begin nmode = MC; m_err = 1'b0; end
                MC: begin nmode = MR; m_cfgd = 1'b1; end
                MR: if (stop && ((m_k == 0) || (e_acc && m_k == 3))) nmode = MD;
                MD: begin
                    live = 0;
                    for (int i = 0; i < fst.size(); i++)
                        if (fgp[i] < 0 && (cyc + 1 - fst[i]) <= OL + 3) live = 1;
                    if (!live) nmode = MI;
                end
                default: nmode = MI;
            endcase
            if (e_gap) begin
                if (fgp.size() > 0) fgp[fgp.size() - 1] = cyc;
                m_err = 1'b1;
                m_k   = 0;
            end
            if (e_acc) begin
                if (m_k == 0) begin
                    fst.push_back(cyc);
                    fgp.push_back(-1);
                end
                m_k = (m_k + 1) % 4;
            end
            m_mode = nmode;
            while (fst.size() > 0 && (cyc - fst[0]) > 12) begin
                void'(fst.pop_front());
                void'(fgp.pop_front());
            end
        end
        n_cmp++;
        if (gv !== ev) begin
            n_bad++;
            $display("FAIL model cycle %0d: dut %05h model %05h", cyc, gv, ev);
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] vt = 8'h1F;   // stop test: in_valid per s
    logic [7:0] st = 8'h1E;   // stop test: stop per s
    logic [7:0] rt = 8'h0F;   // stop test: expected in_ready per s
    logic [7:0] bt = 8'h7F;   // stop test: expected busy per s

    initial begin
        #1 rst = 1'b1;
        repeat (3) begin
            tick(1'b0, 1'b0, 1'b0);
            chkw("reset outputs", outs(), 20'h40000);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Arm: IDLE with start, one CFG cycle, then RUN with delays loaded.
        tick(1'b0, 1'b1, 1'b0);
        chk1("idle busy", busy, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk1("cfg in_ready", in_ready, 1'b0);
        chk1("cfg busy", busy, 1'b1);
        chkw("cfg dnum_s1", {16'd0, dnum_s1}, 20'd0);
        tick(1'b0, 1'b0, 1'b0);
        chk1("run in_ready", in_ready, 1'b1);
        chkw("run dnum_s1", {16'd0, dnum_s1}, 20'd2);
        chkw("run dnum_s2", {16'd0, dnum_s2}, 20'd1);

        // Single frame (samples 0x0100, 0xFF4B, 0x0000, 0x00B5 on the datapath).
        for (int s = 0; s < 9; s++) begin
            tick(s < 4, 1'b0, 1'b0);
            chk_s("single", s, 12'h00C, 12'h028, 12'h020, 12'h078, 12'h008, 12'h040);
        end

        // Two back-to-back frames.
        for (int s = 0; s < 12; s++) begin
            tick(s < 8, 1'b0, 1'b0);
            chk_s("b2b", s, 12'h0CC, 12'h2A8, 12'h220, 12'h7F8, 12'h088, 12'h440);
        end

        // start while running is ignored.
        tick(1'b0, 1'b1, 1'b0);
        chk1("start ignored busy", busy, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk1("start ignored in_ready", in_ready, 1'b1);

        // Mid-frame gap at k=2.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk1("gap err before", err, 1'b0);
        for (int s = 3; s < 8; s++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk1($sformatf("gap no out s=%0d", s), out_valid, 1'b0);
            chk1($sformatf("gap err sticky s=%0d", s), err, 1'b1);
        end
        for (int s = 0; s < 9; s++) begin
            tick(s < 4, 1'b0, 1'b0);
            chk_s("after gap", s, 12'h00C, 12'h028, 12'h020, 12'h078, 12'h008, 12'h040);
        end
        chk1("err still set", err, 1'b1);

        // Stop raised at k=1, dropped again during DRAIN.
        for (int s = 0; s < 8; s++) begin
            tick(vt[s], 1'b0, st[s]);
            chk_s("stop", s, 12'h00C, 12'h028, 12'h020, 12'h078, 12'h008, 12'h040);
            chk1($sformatf("stop in_ready s=%0d", s), in_ready, rt[s]);
            chk1($sformatf("stop busy s=%0d", s), busy, bt[s]);
        end
        chk1("err kept in idle", err, 1'b1);

        // Re-arm clears err.
        tick(1'b0, 1'b1, 1'b0);
        chk1("rearm err before", err, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk1("rearm err cleared", err, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk1("rearm in_ready", in_ready, 1'b1);

        // Asynchronous reset at k=2, between clock edges.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk1("pre-reset bf1", bf1_sel, 1'b1);
        chk1("pre-reset busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        chkw("async reset clear", outs(), 20'h40000);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b0);
            chkw($sformatf("post-reset idle %0d", i),
                 {15'd0, out_valid, busy, bf1_sel, bf2_sel, in_ready}, 20'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft4_sdf_ctrl.md
Name: fft4_sdf_ctrl

Overview:
Sequencing controller for the 4-point radix-2 single-delay-feedback FFT datapath (Q8.8 samples).
- Configures the stage-1 and stage-2 delay lines through their dnum inputs.
- Accepts input samples through a valid/ready handshake.
- Generates the per-cycle butterfly-select and twiddle (-j) select signals, output framing and error flags.
- Sits between the sample source and the butterfly/delay datapath. The datapath clocks every cycle and has no enable; all datapath timing comes from this block.

Parameters:
D1, 2, stage-1 delay depth loaded onto dnum_s1.
D2, 1, stage-2 delay depth loaded onto dnum_s2.
OUT_LAT, 3, cycles from accept of sample 0 to the first valid output.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset; asynchronous and active-high.
start  in  1  pulse; arms the controller from IDLE.
stop  in  1  level; requests return to IDLE at the next frame boundary.
in_valid  in  1  source has a sample.
in_ready  out  1  controller accepts a sample this cycle.
din_zero  out  1  forces the datapath input mux to 0 (no sample accepted this cycle).
dnum_s1  out  4  stage-1 delay count.
dnum_s2  out  4  stage-2 delay count.
bf1_sel  out  1  stage-1 butterfly compute (1) / delay-fill (0).
tw_sel  out  1  multiply the stage-1 output by -j.
bf2_sel  out  1  stage-2 butterfly compute (1) / delay-fill (0).
out_valid  out  1  datapath output is a valid bin.
out_first  out  1  first bin of the frame.
out_last  out  1  last bin of the frame.
out_idx  out  2  bin index of the current output (bit-reversed order).
busy  out  1  state is not IDLE.
err  out  1  sticky; a mid-frame input gap occurred.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - All outputs go to 0, except din_zero=1.
  - dnum_s1 and dnum_s2 = 0.
  - State = IDLE; all counters clear.
- States:
  - IDLE: in_ready=0. start -> CFG.
  - CFG: exactly one cycle. Registers dnum_s1=D1 and dnum_s2=D2, which hold until reset. in_ready=0. Next state RUN.
  - RUN: in_ready=1.
    - A sample is accepted when in_valid && in_ready.
    - A 2-bit sample counter k increments per accept and wraps 3->0.
    - stop sampled with k==0 (frame boundary) -> DRAIN. If mid-frame, the frame is completed first.
  - DRAIN: in_ready=0. Stays until all pending frame schedules have retired (at most OUT_LAT+3 cycles), then -> IDLE.
- din_zero = !(in_valid && in_ready).
- Gap rule: the datapath cannot stall. If k!=0 and in_valid=0 in RUN:
  - err is set (sticky until the next start).
  - k resets to 0.
  - The partial frame's schedule is cancelled: no out_valid is produced for it.
  - The controller stays in RUN.
- Schedule: let s = cycles since accept of sample 0 (s=0 at that accept). Each frame drives:
  - bf1_sel=1 at s=2,3.
  - bf2_sel=1 at s=3,5.
  - tw_sel=1 at s=5.
  - out_valid=1 at s=OUT_LAT..OUT_LAT+3.
  - out_first=1 at s=OUT_LAT; out_last=1 at s=OUT_LAT+3.
  - out_idx at s=OUT_LAT+m is {m[0],m[1]}, giving bin order 0,2,1,3.
- Back-to-back frames: frame n+1 may begin at s=4 of frame n. Up to two frame schedules overlap; each output is the OR of the live schedules. The schedules are disjoint by construction for the same signal, so this needs no arbitration.
- The schedule is driven entirely by registered counters/tags; there are no combinational paths from in_valid to sel outputs other than through in_ready/din_zero.
- start while not IDLE: ignored.
- start and rst together: rst wins.
- stop deasserted during DRAIN: the controller still goes to IDLE.

Test Plan:
- Reset then idle: rst=1 for 3 cycles -> all outputs 0, din_zero=1, dnum 0; start -> CFG one cycle -> dnum_s1=2, dnum_s2=1, in_ready=1 next cycle.
- Single frame: 4 consecutive samples (Q8.8 0x0100, 0xFF4B, 0x0000, 0x00B5) with s=0 at first accept:
  - bf1_sel high at s=2,3; bf2_sel at s=3,5; tw_sel at s=5.
  - out_valid s=3..6 with out_idx 0,2,1,3; out_first s=3, out_last s=6.
- Back-to-back: 8 continuous samples -> out_valid high s=3..10 without a gap, out_first at s=3 and s=7, out_last at s=6 and s=10, tw_sel at s=5 and s=9.
- Mid-frame gap: in_valid low at k=2 -> err=1 next cycle and held; no out_valid for that frame; the next full frame is processed normally; start re-arm clears err.
- Stop: stop asserted at k=1 -> frame completes; in_ready drops after the 4th sample; DRAIN until out_last is seen, then IDLE, busy=0.
- Async reset mid-frame: rst asserted between clock edges at k=2 -> outputs clear immediately without waiting for clk; after release, state is IDLE and no stale out_valid appears.
